// File: rtl/clock_pkg.sv
// Shared definitions for the CPU clock sequencer: FSM encodings and divider helper.
package clock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t STOPPED  = 3'd0;
    localparam state_t RUN      = 3'd1;
    localparam state_t STOPPING = 3'd2;
    localparam state_t STEP_HI  = 3'd3;
    localparam state_t STEP_LO  = 3'd4;
    localparam state_t HALTED   = 3'd5;

    // A divider of 0 would never reach a phase end; treat it as 1.
    function automatic logic [31:0] effDiv(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter: the output follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
    input  logic fastClk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stableCnt;

    // Synchronize the raw button into the fastClk domain.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Accept a new level only once it has been stable long enough; any glitch restarts.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            stableCnt <= '0;
            out       <= 1'b0;
        end else if (sync2 == out) begin
            stableCnt <= '0;
        end else if (stableCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stableCnt <= '0;
            out       <= sync2;
        end else begin
            stableCnt <= stableCnt + CW'(1);
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// CPU clock generator: free-run divided clock, single-step from a debounced button,
// glitch-free stop and halt (a high phase is always completed before stopping).
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             fastClk,
    input  logic             rst,
    input  logic             stepMode,
    input  logic             runEn,
    input  logic             stepBtn,
    input  logic             halt,
    input  logic [31:0]      divider,
    output logic             cpuClk,
    output logic             riseTick,
    output logic             fallTick,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycleCount
);

    logic        dbLevel;
    logic        dbPrev;
    logic        stepReq;
    logic [31:0] halfCnt;
    logic [31:0] halfCntD;
    logic [31:0] divLatch;
    logic [31:0] curDiv;
    logic [31:0] cntNext;
    logic        phaseEnd;
    logic        haltPend;
    logic        haltPendD;
    logic        haltReq;
    logic        stopReq;
    logic        cpuClkD;
    logic        riseD;
    logic        fallD;
    state_t      stateD;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .fastClk(fastClk),
        .rst    (rst),
        .in     (stepBtn),
        .out    (dbLevel)
    );

    assign stepReq = dbLevel & ~dbPrev;

    // The divider is sampled only at a half-period boundary so a phase never changes length.
    assign curDiv   = (halfCnt == 32'd0) ? effDiv(divider) : divLatch;
    assign phaseEnd = (halfCnt == curDiv - 32'd1);
    assign cntNext  = phaseEnd ? 32'd0 : halfCnt + 32'd1;
    assign haltReq  = halt | haltPend;
    assign stopReq  = stepMode | ~runEn;

    // Next-state logic: clock phase counting, stop/halt handling and step sequencing.
    always_comb begin
        stateD    = state;
        cpuClkD   = cpuClk;
        halfCntD  = halfCnt;
        haltPendD = haltPend;
        riseD     = 1'b0;
        fallD     = 1'b0;
        case (state)
            STOPPED: begin
                cpuClkD  = 1'b0;
                halfCntD = 32'd0;
                if (haltReq) begin
                    stateD = HALTED;
                end else if (!stepMode && runEn) begin
                    stateD = RUN;
                end else if (stepMode && stepReq) begin
                    stateD  = STEP_HI;
                    cpuClkD = 1'b1;
                    riseD   = 1'b1;
                end
            end
            RUN: begin
                if (!cpuClk) begin
                    if (haltReq) begin
                        stateD   = HALTED;
                        halfCntD = 32'd0;
                    end else if (stopReq) begin
                        stateD   = STOPPED;
                        halfCntD = 32'd0;
                    end else begin
                        halfCntD = cntNext;
                        if (phaseEnd) begin
                            cpuClkD = 1'b1;
                            riseD   = 1'b1;
                        end
                    end
                end else begin
                    // High phase always runs to completion; halt is remembered until then.
                    haltPendD = haltReq;
                    halfCntD  = cntNext;
                    if (phaseEnd) begin
                        cpuClkD = 1'b0;
                        fallD   = 1'b1;
                        if (haltReq) begin
                            stateD = HALTED;
                        end else if (stopReq) begin
                            stateD = STOPPED;
                        end
                    end else if (!haltReq && stopReq) begin
                        stateD = STOPPING;
                    end
                end
            end
            STOPPING, STEP_HI: begin
                haltPendD = haltReq;
                halfCntD  = cntNext;
                if (phaseEnd) begin
                    cpuClkD = 1'b0;
                    fallD   = 1'b1;
                    if (haltReq) begin
                        stateD = HALTED;
                    end else if (state == STEP_HI) begin
                        stateD = STEP_LO;
                    end else begin
                        stateD = STOPPED;
                    end
                end
            end
            STEP_LO: begin
                if (haltReq) begin
                    stateD   = HALTED;
                    halfCntD = 32'd0;
                end else begin
                    halfCntD = cntNext;
                    if (phaseEnd) begin
                        stateD = STOPPED;
                    end
                end
            end
            HALTED: begin
                cpuClkD   = 1'b0;
                halfCntD  = 32'd0;
                haltPendD = 1'b0;
            end
            default: begin
                stateD    = STOPPED;
                cpuClkD   = 1'b0;
                halfCntD  = 32'd0;
                haltPendD = 1'b0;
            end
        endcase
    end

    // State, clock and tick registers; ticks are registered alongside cpuClk.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            state      <= STOPPED;
            cpuClk     <= 1'b0;
            riseTick   <= 1'b0;
            fallTick   <= 1'b0;
            cycleCount <= '0;
            halfCnt    <= 32'd0;
            divLatch   <= 32'd1;
            haltPend   <= 1'b0;
            dbPrev     <= 1'b0;
        end else begin
            state    <= stateD;
            cpuClk   <= cpuClkD;
            riseTick <= riseD;
            fallTick <= fallD;
            halfCnt  <= halfCntD;
            divLatch <= curDiv;
            haltPend <= haltPendD;
            dbPrev   <= dbLevel;
            if (riseD) begin
                cycleCount <= cycleCount + CNT_W'(1);
            end
        end
    end

endmodule
